// File: rtl/bufram_linebuf.sv
// Multi-line burst buffer between the SDRAM FSM (fill side) and its consumer
// (drain side). Lines are filled sequentially with byte enables, committed
// when BURST_LEN words have been written, read at random offsets from the
// oldest committed line, and then retired. The ring is NUM_LINES deep.
module bufram_linebuf #(
  parameter string TECHNOLOGY = "GENERIC",
  parameter int    DATA_WIDTH = 32,
  parameter int    BURST_LEN  = 8,
  parameter int    NUM_LINES  = 4,
  localparam int   LW         = $clog2(BURST_LEN),
  localparam int   NW         = $clog2(NUM_LINES),
  localparam int   NB         = DATA_WIDTH / 8
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_be,
  input  logic                  wr_abort,
  output logic                  wr_ready,
  output logic                  wr_commit,
  input  logic                  rd_en,
  input  logic [LW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  line_pop,
  output logic                  line_avail,
  output logic [NW:0]           lines_used
);

  localparam int DEPTH = NUM_LINES * BURST_LEN;

  logic [NW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         word_cnt_q, word_cnt_d;
  logic [NW:0]           lines_used_q, lines_used_d;
  logic                  wr_commit_q, wr_commit_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  wr_accept;
  logic                  commit;
  logic                  pop;
  logic                  rd_fire;
  logic [NW+LW-1:0]      wr_phys;
  logic [NW+LW-1:0]      rd_phys;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign wr_ready   = (lines_used_q != (NW+1)'(NUM_LINES));
  assign line_avail = (lines_used_q != '0);
  assign wr_commit  = wr_commit_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign lines_used = lines_used_q;

  // The fill line is never the head line, so a read and a write in the same
  // cycle can never touch the same physical word.
  assign wr_phys = {wr_ptr_q, word_cnt_q};
  assign rd_phys = {rd_ptr_q, rd_addr};

  // Storage: byte-masked write port, combinational read feeding rd_data_q.
  generate
    if (TECHNOLOGY == "ALTERA") begin : g_altera
      (* ramstyle = "no_rw_check" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

      // Byte-enabled fill write into the vendor-mapped block RAM.
      always_ff @(posedge sdram_clk) begin
        if (wr_accept) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_phys][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      assign mem_rdata = mem[rd_phys];
    end else begin : g_generic
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      // NOTE: the storage array has no reset; clearing it would defeat RAM
      // inference, and no line is readable before it has been fully written.
      always_ff @(posedge sdram_clk) begin
        if (wr_accept) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_phys][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      assign mem_rdata = mem[rd_phys];
    end
  endgenerate

  // Next-state logic for pointers, fill counter, line count and drain port.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    wr_accept    = wr_en & wr_ready & ~wr_abort;
    commit       = wr_accept & (word_cnt_q == LW'(BURST_LEN - 1));
    pop          = line_pop & line_avail;
    rd_fire      = rd_en & line_avail;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    word_cnt_d   = word_cnt_q;
    lines_used_d = lines_used_q;
    wr_commit_d  = commit;
    rd_valid_d   = rd_fire;
    rd_data_d    = rd_data_q;

    if (wr_abort) begin
      word_cnt_d = '0;
    end else if (wr_accept) begin
      word_cnt_d = word_cnt_q + LW'(1);
    end

    if (commit) wr_ptr_d = wr_ptr_q + NW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + NW'(1);

    // Commit and pop together leave the count unchanged.
    if (commit && !pop)      lines_used_d = lines_used_q + (NW+1)'(1);
    else if (pop && !commit) lines_used_d = lines_used_q - (NW+1)'(1);

    // The read uses the pre-pop head pointer.
    if (rd_fire) rd_data_d = mem_rdata;
  end

  // State registers with synchronous reset; reset drops every line.
  always_ff @(posedge sdram_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (sdram_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_cnt_q   <= '0;
      lines_used_q <= '0;
      wr_commit_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_cnt_q   <= word_cnt_d;
      lines_used_q <= lines_used_d;
      wr_commit_q  <= wr_commit_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_bufram_linebuf.sv
// Directed bench for bufram_linebuf with 32-bit words, 8-word lines, 4 lines.
module tb_bufram_linebuf;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_abort;
  logic        wr_ready;
  logic        wr_commit;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        line_pop;
  logic        line_avail;
  logic [2:0]  lines_used;

  int total = 0;
  int bad   = 0;

  bufram_linebuf #(
    .TECHNOLOGY("GENERIC"),
    .DATA_WIDTH(32),
    .BURST_LEN (8),
    .NUM_LINES (4)
  ) dut (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_abort  (wr_abort),
    .wr_ready  (wr_ready),
    .wr_commit (wr_commit),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .line_pop  (line_pop),
    .line_avail(line_avail),
    .lines_used(lines_used)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs set beforehand take effect at the next rising edge; outputs are
  // sampled 1 ns after it.
  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_data = d;
    wr_be   = be;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] base);
    for (int i = 0; i < 8; i++) write_word(base + 32'(i), 4'hF);
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, rd_data, exp);
  endtask

  task automatic pop_line();
    line_pop = 1'b1;
    step();
    line_pop = 1'b0;
  endtask

  initial begin
    sdram_rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; wr_be = '0; wr_abort = 1'b0;
    rd_en = 1'b0; rd_addr = '0; line_pop = 1'b0;
    step();
    step();
    sdram_rst = 1'b0;

    // 1: reset values, one line, random read
    check("rst_wr_ready",   32'(wr_ready),   32'd1);
    check("rst_wr_commit",  32'(wr_commit),  32'd0);
    check("rst_line_avail", 32'(line_avail), 32'd0);
    check("rst_rd_valid",   32'(rd_valid),   32'd0);
    check("rst_rd_data",    rd_data,         32'd0);
    check("rst_lines_used", 32'(lines_used), 32'd0);
    fill_line(32'h00);
    check("t1_commit",     32'(wr_commit),  32'd1);
    check("t1_line_avail", 32'(line_avail), 32'd1);
    check("t1_lines_used", 32'(lines_used), 32'd1);
    step();
    check("t1_commit_pulse", 32'(wr_commit), 32'd0);
    read_check("t1_rd5", 3'd5, 32'h05);
    step();
    check("t1_valid_pulse", 32'(rd_valid), 32'd0);
    check("t1_rd_hold",     rd_data,       32'h05);

    // 2: fill to full, ignored write, pop, wrap into line 0
    fill_line(32'h10);
    fill_line(32'h20);
    fill_line(32'h30);
    check("t2_full_used",  32'(lines_used), 32'd4);
    check("t2_full_ready", 32'(wr_ready),   32'd0);
    write_word(32'h99, 4'hF);
    check("t2_ignored_used", 32'(lines_used), 32'd4);
    read_check("t2_head_rd0", 3'd0, 32'h00);
    pop_line();
    check("t2_pop_used",  32'(lines_used), 32'd3);
    check("t2_pop_ready", 32'(wr_ready),   32'd1);
    read_check("t2_line1_rd0", 3'd0, 32'h10);
    fill_line(32'h40);
    check("t2_wrap_used", 32'(lines_used), 32'd4);
    pop_line();
    read_check("t2_line2_rd6", 3'd6, 32'h26);
    pop_line();
    read_check("t2_line3_rd7", 3'd7, 32'h37);
    pop_line();
    read_check("t2_wrap_rd0", 3'd0, 32'h40);
    read_check("t2_wrap_rd7", 3'd7, 32'h47);
    pop_line();
    check("t2_empty_used",  32'(lines_used), 32'd0);
    check("t2_empty_avail", 32'(line_avail), 32'd0);

    // 3: byte enables on a pre-filled slot (prefill, abort, refill same line)
    for (int i = 0; i < 3; i++) write_word(32'hFFFF_FFFF, 4'hF);
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    write_word(32'h0, 4'hF);
    write_word(32'h1, 4'hF);
    write_word(32'h1234_5678, 4'b0101);
    for (int i = 3; i < 8; i++) write_word(32'(i), 4'hF);
    check("t3_used", 32'(lines_used), 32'd1);
    read_check("t3_be_rd2", 3'd2, 32'hFF34_FF78);
    read_check("t3_rd0",    3'd0, 32'h0);
    pop_line();

    // 4: abort after 3 words, abort beating a write, then a clean line
    for (int i = 0; i < 3; i++) write_word(32'h55, 4'hF);
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    write_word(32'h66, 4'hF);
    write_word(32'h66, 4'hF);
    wr_abort = 1'b1;
    write_word(32'h77, 4'hF);
    wr_abort = 1'b0;
    for (int i = 0; i < 7; i++) write_word(32'hA0 + 32'(i), 4'hF);
    check("t4_no_early_commit", 32'(wr_commit),  32'd0);
    check("t4_used_before",     32'(lines_used), 32'd0);
    write_word(32'hA7, 4'hF);
    check("t4_commit",     32'(wr_commit),  32'd1);
    check("t4_used_after", 32'(lines_used), 32'd1);
    read_check("t4_rd0", 3'd0, 32'hA0);
    read_check("t4_rd3", 3'd3, 32'hA3);
    read_check("t4_rd7", 3'd7, 32'hA7);

    // 5: commit + pop + read in the same cycle
    fill_line(32'hB0);
    check("t5_used2", 32'(lines_used), 32'd2);
    for (int i = 0; i < 7; i++) write_word(32'hC0 + 32'(i), 4'hF);
    line_pop = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 3'd4;
    write_word(32'hC7, 4'hF);
    line_pop = 1'b0;
    rd_en    = 1'b0;
    check("t5_used_same",  32'(lines_used), 32'd2);
    check("t5_commit",     32'(wr_commit),  32'd1);
    check("t5_old_valid",  32'(rd_valid),   32'd1);
    check("t5_old_head",   rd_data,         32'hA4);
    read_check("t5_new_head", 3'd4, 32'hB4);

    // 6: reset mid-burst, then pop/read on empty
    for (int i = 0; i < 5; i++) write_word(32'hD0 + 32'(i), 4'hF);
    sdram_rst = 1'b1;
    step();
    sdram_rst = 1'b0;
    check("t6_wr_ready",   32'(wr_ready),   32'd1);
    check("t6_wr_commit",  32'(wr_commit),  32'd0);
    check("t6_line_avail", 32'(line_avail), 32'd0);
    check("t6_rd_valid",   32'(rd_valid),   32'd0);
    check("t6_rd_data",    rd_data,         32'd0);
    check("t6_lines_used", 32'(lines_used), 32'd0);
    line_pop = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 3'd1;
    step();
    line_pop = 1'b0;
    rd_en    = 1'b0;
    check("t6_empty_valid", 32'(rd_valid),   32'd0);
    check("t6_empty_used",  32'(lines_used), 32'd0);
    check("t6_empty_data",  rd_data,         32'd0);
    fill_line(32'hE0);
    read_check("t6_refill_rd3", 3'd3, 32'hE3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
